// File: rtl/pkt_tx_pkg.sv
// Shared switch defines (packet width, flag values, flit width, TX state codes)
// and the pkt_tx package with the state type and the parity helper.
`ifndef SW_VH
`define SW_VH
`define PKTW      31
`define ASSERT    1'b1
`define NEGATE    1'b0
`define FLITW_DEF 8
`define TX_IDLE   1'b0
`define TX_SEND   1'b1
`endif

package pkt_tx_pkg;

    typedef enum logic {
        ST_IDLE = `TX_IDLE,
        ST_SEND = `TX_SEND
    } tx_state_e;

    // Even parity; zero-extension of narrower flits does not change the result.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/pkt_tx.sv
// pkt_tx: pops whole packets from an output queue and serialises them MSB flit first.
// Optional PKT_TX_PARITY_EN adds the registered even-parity output tx_par.
module pkt_tx
    import pkt_tx_pkg::*;
#(
    parameter int PW    = `PKTW + 1,
    parameter int FLITW = `FLITW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PW-1:0]    q_data,
    input  logic             q_empty,
    output logic             q_re,
    output logic [FLITW-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic [15:0]      pkt_cnt
`ifdef PKT_TX_PARITY_EN
    ,
    output logic             tx_par
`endif
);

    localparam int NFLIT = PW / FLITW;
    localparam int IW    = $clog2(NFLIT);
    localparam logic [IW-1:0] LAST = IW'(NFLIT - 1);

    tx_state_e     state_r;
    tx_state_e     state_nx_s;
    logic [PW-1:0] sr_r;
    logic [IW-1:0] idx_r;
    logic [15:0]   cnt_r;
    logic          load_s;
    logic          shift_s;
    logic          done_s;

    // Next state and datapath controls; a load always coincides with a pop.
    always_comb begin
        state_nx_s = state_r;
        load_s     = `NEGATE;
        shift_s    = `NEGATE;
        done_s     = `NEGATE;
        case (state_r)
            ST_IDLE: begin
                if (!q_empty) begin
                    load_s     = `ASSERT;
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_r == LAST) begin
                        done_s = `ASSERT;
                        if (!q_empty) begin
                            load_s     = `ASSERT;
                            state_nx_s = ST_SEND;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        shift_s = `ASSERT;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // No pop during reset: the loaded packet would be discarded by the reset itself.
    assign q_re = load_s & ~rst;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Packet shift register and flit index
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r  <= {PW{1'b0}};
            idx_r <= {IW{1'b0}};
        end else if (load_s) begin
            sr_r  <= q_data;
            idx_r <= {IW{1'b0}};
        end else if (shift_s) begin
            sr_r  <= sr_r << FLITW;
            idx_r <= idx_r + IW'(1);
        end else begin
            sr_r  <= sr_r;
            idx_r <= idx_r;
        end
    end

    // Saturating count of fully sent packets
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'h0000;
        end else if (done_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tx_valid = (state_r == ST_SEND);
    assign tx_data  = tx_valid ? sr_r[PW-1 -: FLITW] : {FLITW{1'b0}};
    assign tx_sop   = tx_valid & (idx_r == {IW{1'b0}});
    assign tx_eop   = tx_valid & (idx_r == LAST);
    assign pkt_cnt  = cnt_r;

`ifdef PKT_TX_PARITY_EN
    logic par_r;

    // Parity of the flit that sr will present next, so it lines up with tx_data
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else if (load_s) begin
            par_r <= even_par(64'(q_data[PW-1 -: FLITW]));
        end else if (shift_s) begin
            par_r <= even_par(64'(sr_r[PW-FLITW-1 -: FLITW]));
        end else begin
            par_r <= par_r;
        end
    end

    assign tx_par = par_r & tx_valid;
`else
    // Parity disabled: no tx_par port and no parity state.
`endif

endmodule

// File: tb/tb_pkt_tx.sv
// Self-checking bench for pkt_tx: directed vector table, hand sequences and
// randomized traffic against a packet-level reference model.
module tb_pkt_tx;

    localparam int PW    = 32;
    localparam int FLITW = 8;
    localparam int NFLIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] q_data;
    logic        q_empty;
    logic        q_re;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic [15:0] pkt_cnt;
`ifdef PKT_TX_PARITY_EN
    logic        tx_par;
`endif

    always #5 clk = ~clk;

    pkt_tx #(.PW(PW), .FLITW(FLITW)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_data   (q_data),
        .q_empty  (q_empty),
        .q_re     (q_re),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .pkt_cnt  (pkt_cnt)
`ifdef PKT_TX_PARITY_EN
        ,
        .tx_par   (tx_par)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue contents, packet in flight and flits still to send.
    logic [31:0] tbq[$];
    logic [31:0] cur = 32'h0;
    int          nrem = 0;
    int          mcnt = 0;

    // Per-scenario observations of the DUT
    int          vcnt, qcnt, first_v, last_v, cyc;
    logic        sop_seen;
    logic [7:0]  sop_data;

    typedef struct {
        logic [31:0] p0;
        logic [31:0] p1;
        int          npkt;
        int          stall_flit;
        int          stall_len;
        int          exp_valid;
        int          exp_qre;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clr_obs();
        vcnt = 0; qcnt = 0; first_v = -1; last_v = -1; cyc = 0;
        sop_seen = 1'b0; sop_data = 8'h00;
    endtask

    function automatic logic model_pop();
        return !rst && (tbq.size() > 0) && (nrem == 0 || (tx_ready && nrem == 1));
    endfunction

    task automatic check_model();
        logic [7:0] ed;
        chk("tx_valid", tx_valid, nrem > 0);
        chk("q_re", q_re, model_pop());
        chk("pkt_cnt", pkt_cnt, mcnt[15:0]);
        if (nrem > 0) begin
            ed = 8'(cur >> (FLITW * (nrem - 1)));
            chk("tx_data", tx_data, ed);
            chk("tx_sop", tx_sop, nrem == NFLIT);
            chk("tx_eop", tx_eop, nrem == 1);
`ifdef PKT_TX_PARITY_EN
            chk("tx_par", tx_par, ^ed);
`endif
        end else begin
            chk("tx_sop_idle", tx_sop, 1'b0);
            chk("tx_eop_idle", tx_eop, 1'b0);
`ifdef PKT_TX_PARITY_EN
            chk("tx_par_idle", tx_par, 1'b0);
`endif
        end
    endtask

    // One clock: drive inputs, check at negedge, advance the model, wait past posedge.
    task automatic cycle(input logic rdy, input logic r);
        logic pop;
        tx_ready = rdy;
        rst      = r;
        q_empty  = (tbq.size() == 0);
        q_data   = q_empty ? 32'h0 : tbq[0];
        @(negedge clk);
        check_model();
        if (tx_valid) begin
            vcnt++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            if (tx_sop && !sop_seen) begin
                sop_data = tx_data;
                sop_seen = 1'b1;
            end
        end
        if (q_re) qcnt++;
        pop = model_pop();
        if (r) begin
            nrem = 0;
            mcnt = 0;
        end else begin
            if (nrem > 0 && rdy) begin
                nrem--;
                if (nrem == 0 && mcnt < 65535) mcnt++;
            end
            if (pop) begin
                cur  = tbq.pop_front();
                nrem = NFLIT;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cum;
        int stalled;
        logic rdy;

        vecs[0] = '{32'hA1B2C3D4, 32'h0,        1, 0, 0, 4, 1, 1};
        vecs[1] = '{32'h11223344, 32'h55667788, 2, 0, 0, 8, 2, 2};
        vecs[2] = '{32'hA1B2C3D4, 32'h0,        1, 2, 3, 7, 1, 1};
        vecs[3] = '{32'h0703FF01, 32'h0,        1, 0, 0, 4, 1, 1};

        rst = 1'b1; tx_ready = 1'b0; q_empty = 1'b1; q_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", tx_valid, 1'b0);
        chk("reset_q_re", q_re, 1'b0);
        chk("reset_sop", tx_sop, 1'b0);
        chk("reset_eop", tx_eop, 1'b0);
        chk("reset_data", tx_data, 8'h00);
        chk("reset_cnt", pkt_cnt, 16'h0000);
`ifdef PKT_TX_PARITY_EN
        chk("reset_par", tx_par, 1'b0);
`endif
        @(posedge clk);
        #1;

        cum = 0;
        for (int v = 0; v < 4; v++) begin
            clr_obs();
            tbq.push_back(vecs[v].p0);
            if (vecs[v].npkt > 1) tbq.push_back(vecs[v].p1);
            stalled = 0;
            for (int c = 0; c < 16; c++) begin
                rdy = 1'b1;
                if (vecs[v].stall_len > 0 && nrem > 0 &&
                    (NFLIT - nrem) == vecs[v].stall_flit && stalled < vecs[v].stall_len) begin
                    rdy = 1'b0;
                    stalled++;
                end
                cycle(rdy, 1'b0);
            end
            cum += vecs[v].exp_cnt;
            chk($sformatf("vec%0d_valid_cycles", v), vcnt, vecs[v].exp_valid);
            chk($sformatf("vec%0d_q_re_pulses", v), qcnt, vecs[v].exp_qre);
            chk($sformatf("vec%0d_contiguous", v), last_v - first_v + 1, vecs[v].exp_valid);
            chk($sformatf("vec%0d_first_sop", v), sop_data, vecs[v].p0[31:24]);
            chk($sformatf("vec%0d_pkt_cnt", v), pkt_cnt, cum);
        end

        // Empty queue for 20 cycles with arbitrary tx_ready
        clr_obs();
        for (int c = 0; c < 20; c++) cycle(1'($urandom_range(0, 1)), 1'b0);
        chk("idle_valid_cycles", vcnt, 0);
        chk("idle_q_re_pulses", qcnt, 0);
        chk("idle_pkt_cnt", pkt_cnt, cum);

        // Reset after flit B2 is accepted; the next packet starts cleanly
        clr_obs();
        tbq.push_back(32'hA1B2C3D4);
        tbq.push_back(32'h5A6B7C8D);
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        chk("midrst_valid", tx_valid, 1'b0);
        chk("midrst_cnt", pkt_cnt, 16'h0000);
        chk("midrst_data", tx_data, 8'h00);
        clr_obs();
        repeat (8) cycle(1'b1, 1'b0);
        chk("midrst_next_sop", sop_data, 8'h5A);
        chk("midrst_next_valid", vcnt, 4);
        chk("midrst_next_cnt", pkt_cnt, 16'h0001);

        // Randomized traffic, stalls and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 25 && tbq.size() < 8) tbq.push_back($urandom);
            cycle(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
